// File: rtl/addsub_accumulator.sv
// Command front-end for an external two's-complement adder-subtractor; owns the accumulator and result flags.
// Latency: command accepted at edge t, out_valid sampled high at edge t+2; at most one command in flight.
// Backpressure: in_ready only in IDLE; RESP is held with stable acc/flags until out_ready.
module addsub_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  // command side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  // external adder
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_k,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_ovf,
  // result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             res_ovf,
  output logic             ovf_sticky,
  output logic             res_zero,
  output logic             res_neg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_k_q, add_k_d;
  logic             res_ovf_q, res_ovf_d;
  logic             sticky_q, sticky_d;

  // Handshake FSM: next state and the two handshake outputs, decoded from state only.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_EXEC;
        end
      end
      // Single cycle for the adder to settle on acc/add_b/add_k.
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture the command on accept, commit the result at the end of EXEC.
  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    add_b_d   = add_b_q;
    add_k_d   = add_k_q;
    res_ovf_d = res_ovf_q;
    sticky_d  = sticky_q;
    if (state_q == ST_IDLE && in_valid) begin
      op_d    = op_t'(in_op);
      add_b_d = in_operand;
      add_k_d = (in_op == OP_SUB);
    end
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          // Overflow is taken from the adder as-is; acc wraps, never saturates.
          acc_d     = add_sum;
          res_ovf_d = add_ovf;
          sticky_d  = sticky_q | add_ovf;
        end
        OP_LOAD: begin
          acc_d     = add_b_q;
          res_ovf_d = 1'b0;
        end
        default: begin
          acc_d     = '0;
          res_ovf_d = 1'b0;
          sticky_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      acc_q     <= '0;
      add_b_q   <= '0;
      add_k_q   <= 1'b0;
      res_ovf_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      add_b_q   <= add_b_d;
      add_k_q   <= add_k_d;
      res_ovf_q <= res_ovf_d;
      sticky_q  <= sticky_d;
    end
  end

  // Adder operands come straight from registers; A always tracks the accumulator.
  always_comb begin
    add_a      = acc_q;
    add_b      = add_b_q;
    add_k      = add_k_q;
    acc        = acc_q;
    res_ovf    = res_ovf_q;
    ovf_sticky = sticky_q;
    res_zero   = (acc_q == '0);
    res_neg    = acc_q[WIDTH-1];
  end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator with a behavioural adder attached.
// Stimulus pushes hand-computed results into a scoreboard; a monitor pops on each output handshake.
// Latency, hold/backpressure and mid-command reset are checked alongside.
module tb_addsub_accumulator;
  localparam int W = 4;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_operand;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_k, add_ovf;
  logic         out_valid, out_ready;
  logic [W-1:0] acc;
  logic         res_ovf, ovf_sticky, res_zero, res_neg;

  addsub_accumulator #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_operand(in_operand),
    .add_a(add_a), .add_b(add_b), .add_k(add_k), .add_sum(add_sum), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .res_ovf(res_ovf), .ovf_sticky(ovf_sticky), .res_zero(res_zero), .res_neg(res_neg)
  );

  // External adder-subtractor: A + (B ^ K) + K, signed overflow.
  logic [W-1:0] b_eff;
  assign b_eff   = add_b ^ {W{add_k}};
  assign add_sum = add_a + b_eff + {{(W-1){1'b0}}, add_k};
  assign add_ovf = (add_a[W-1] == b_eff[W-1]) && (add_sum[W-1] != add_a[W-1]);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] acc;
    logic         ovf;
    logic         sticky;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one command; waits (bounded) for in_ready, returns at the negedge inside EXEC.
  task automatic send(input logic [1:0] op, input logic [W-1:0] opnd, input bit track,
                      input logic [W-1:0] e_acc, input bit e_ovf, input bit e_sticky);
    int waitc = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_operand = opnd;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      e.acc = e_acc; e.ovf = e_ovf; e.sticky = e_sticky; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    chk("exec_add_k", 32'(add_k), 32'(op == SUB));
    chk("exec_add_b", 32'(add_b), 32'(opnd));
  endtask

  task automatic wait_idle();
    int waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  // Monitor: latency on out_valid rise, result compare on each output handshake.
  initial begin
    bit prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          chk("sb_has_entry_at_valid", 32'(sb.size() != 0), 32'd1);
          // cyc+1 is the first edge at which the consumer samples out_valid.
          if (sb.size() != 0) chk("latency", 32'(cyc + 1), 32'(sb[0].cyc + 2));
        end
        if (out_valid && out_ready) begin
          chk("sb_has_entry_at_pop", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("acc", 32'(acc), 32'(e.acc));
            chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
            chk("ovf_sticky", 32'(ovf_sticky), 32'(e.sticky));
            chk("res_zero", 32'(res_zero), 32'(e.acc == '0));
            chk("res_neg", 32'(res_neg), 32'(e.acc[W-1]));
          end
        end
        prev = out_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = ADD; in_operand = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_res_zero", 32'(res_zero), 32'd1);
    chk("rst_res_neg", 32'(res_neg), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_res_ovf", 32'(res_ovf), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_add_k", 32'(add_k), 32'd0);
    reset = 1'b0;

    // Basic load/add.
    send(LOAD, 4'd3, 1, 4'b0011, 0, 0);
    send(ADD,  4'd4, 1, 4'b0111, 0, 0);
    // Positive overflow, then sticky persistence, then clear.
    send(LOAD, 4'd7, 1, 4'b0111, 0, 0);
    send(ADD,  4'd1, 1, 4'b1000, 1, 1);
    send(ADD,  4'd0, 1, 4'b1000, 0, 1);
    send(CLR,  4'd9, 1, 4'b0000, 0, 0);
    // Subtract to a negative result, then negative overflow.
    send(LOAD, 4'd2, 1, 4'b0010, 0, 0);
    send(SUB,  4'd5, 1, 4'b1101, 0, 0);
    send(LOAD, 4'd8, 1, 4'b1000, 0, 0);
    send(SUB,  4'd1, 1, 4'b0111, 1, 1);

    // Backpressure hold with an ignored command pulse.
    wait_idle();
    out_ready = 1'b0;
    send(LOAD, 4'd5, 1, 4'b0101, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = (i == 1);
      in_op = LOAD; in_operand = 4'd9;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_acc", 32'(acc), 32'd5);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_acc", 32'(acc), 32'd5);

    // Reset in the middle of EXEC discards the command.
    send(LOAD, 4'd6, 1, 4'b0110, 0, 1);
    send(ADD,  4'd1, 0, 4'b0000, 0, 0);
    reset = 1'b1;
    #1;
    chk("midrst_acc", 32'(acc), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    send(ADD, 4'd2, 1, 4'b0010, 0, 0);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
- Sequential front-end for the 4-bit two's-complement adder-subtractor.
- Accepts ADD/SUB/LOAD/CLEAR commands over a valid/ready handshake and drives the external adder's A, B and K inputs from registers.
- Captures the adder's SUM and overflow outputs into an accumulator, then presents each result with flags over an output valid/ready handshake.
- Sits between the operand source (switches, test sequencer) and the display or result consumer.

Parameters:
- WIDTH, 4: datapath width. Must match the adder instance; all arithmetic is two's complement at this width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command.
- in_op  input  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- in_operand  input  WIDTH  operand B for ADD/SUB, value for LOAD; ignored for CLEAR.
- add_a  output  WIDTH  to adder A; always equals acc.
- add_b  output  WIDTH  to adder B; registered operand.
- add_k  output  1  to adder K; 1 for SUB, else 0.
- add_sum  input  WIDTH  from adder SUM.
- add_ovf  input  1  from adder overflow.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- acc  output  WIDTH  accumulator value.
- res_ovf  output  1  overflow of the most recent ADD/SUB; 0 after LOAD or CLEAR.
- ovf_sticky  output  1  set by any ADD/SUB overflow; cleared only by CLEAR or reset.
- res_zero  output  1  acc == 0.
- res_neg  output  1  acc[WIDTH-1].

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. acc, add_b, add_k, res_ovf, ovf_sticky and out_valid all go to 0. in_ready goes to 1, res_zero to 1, res_neg to 0. Any in-flight command is discarded.
- FSM states: IDLE, EXEC, RESP.

IDLE:
- in_ready=1, out_valid=0.
- On in_valid=1, the command is accepted at that clock edge:
  - op is registered.
  - add_b is loaded with in_operand.
  - add_k is loaded with 1 if op=SUB, else 0.
  - State moves to EXEC.

EXEC (exactly one cycle):
- in_ready=0. The adder settles combinationally from acc, add_b and add_k.
- At the clock edge, by op:
  - ADD/SUB: acc<=add_sum; res_ovf<=add_ovf; ovf_sticky<=ovf_sticky|add_ovf.
  - LOAD: acc<=add_b; res_ovf<=0.
  - CLEAR: acc<=0; res_ovf<=0; ovf_sticky<=0.
- State moves to RESP.

RESP:
- out_valid=1, in_ready=0. acc and the flags are stable.
- On out_ready=1: state moves to IDLE, and out_valid drops on the next cycle.
- If out_ready=0, the block holds RESP indefinitely (backpressure).

Timing and handshake:
- Latency: command accepted at edge t → out_valid high from edge t+2.
- Minimum spacing is 3 cycles per command when out_ready is tied high.
- in_valid during EXEC or RESP is ignored and not queued. The source must hold it until in_ready.
- add_b and add_k keep their values after EXEC until the next accept.
- res_zero and res_neg are combinational from acc.
- Overflow is whatever the adder reports (carry into MSB XOR carry out). The block does not recompute it. acc wraps modulo 2^WIDTH and is never saturated.
- No command can complete during reset. A reset asserted in EXEC or RESP leaves acc=0 when it releases.

Test Plan:
- reset, then LOAD 3, ADD 4 → acc=0111, res_ovf=0, res_zero=0, res_neg=0, out_valid exactly 2 cycles after each accept.
- LOAD 7, ADD 1 → acc=1000, res_ovf=1, ovf_sticky=1, res_neg=1. Then ADD 0 → res_ovf=0 while ovf_sticky stays 1. Then CLEAR → acc=0000, ovf_sticky=0, res_zero=1.
- LOAD 2, SUB 5 → add_k=1 during EXEC, acc=1101 (-3), res_ovf=0, res_neg=1.
- LOAD 8 (1000), SUB 1 → acc=0111, res_ovf=1.
- LOAD 5 with out_ready=0 for 4 cycles → out_valid held, acc=0101 stable, in_ready=0. A second in_valid pulse during the hold is ignored. Raising out_ready → IDLE the next cycle.
- LOAD 6 completes, then ADD 1 accepted and reset asserted mid-EXEC → acc=0000, out_valid=0, in_ready=1 immediately. After release, ADD 2 → acc=0010.
